// File: rtl/serial_subtractor_pkg.sv
// Shared constants and the state type for the bit-serial subtractor.
// Optional signed-overflow output is enabled by defining SERSUB_OVF_EN.
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_SHIFT = 2'd1;
   localparam logic [1:0] STATE_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = STATE_IDLE,
      SHIFT = STATE_SHIFT,
      DONE  = STATE_DONE
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERSUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b,
                   input  ready, busy, done, diff, borrow, ovf);
   modport slave  (input  start, a, b,
                   output ready, busy, done, diff, borrow, ovf);
`else
   modport master (output start, a, b,
                   input  ready, busy, done, diff, borrow);
   modport slave  (input  start, a, b,
                   output ready, busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module serial_subtractor_full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference and borrow-out of one bit position
   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock.
// Define SERSUB_OVF_EN to add the signed two's-complement overflow output ovf.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned MSB   = WIDTH - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] result;
   logic             bflop;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             step;
   logic             finish;
   logic             fs_d;
   logic             fs_bout;

   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
`ifdef SERSUB_OVF_EN
   logic             sgn_differ_q;
   logic             a_msb_q;
   logic             ovf_q;
`endif

   serial_subtractor_full_subtractor u_full_subtractor (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (bflop),
      .d    (fs_d),
      .bout (fs_bout)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               state_n = DONE;
            end
         end
         DONE: begin
            finish  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand shift registers, borrow flop, bit counter and result accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         result <= '0;
         bflop  <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         result <= '0;
         bflop  <= 1'b0;
         cnt    <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         result <= {fs_d, result[MSB:1]};
         bflop  <= fs_bout;
         // Hold on the last bit so the counter never wraps
         if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         ready_q <= (state_n == IDLE);
         busy_q  <= (state_n == SHIFT);
         done_q  <= finish;
         if (load) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
         end else if (finish) begin
            diff_q   <= result;
            borrow_q <= bflop;
         end
      end
   end

`ifdef SERSUB_OVF_EN
   // Signed overflow: operand signs differ and result sign differs from a
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgn_differ_q <= 1'b0;
         a_msb_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else if (load) begin
         sgn_differ_q <= bus.a[MSB] ^ bus.b[MSB];
         a_msb_q      <= bus.a[MSB];
         ovf_q        <= 1'b0;
      end else if (finish) begin
         ovf_q <= sgn_differ_q & (result[MSB] ^ a_msb_q);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.ready  = ready_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;

endmodule
